// File: rtl/alu_issue.sv
// alu_issue: two-stage issue unit for an external 8-bit ALU.
// The ACCEPT stage reads operands from an 8 x 8-bit register file, with optional
// forwarding. The single EXEC slot drives the ALU and writes the result back.
module alu_issue #(
   parameter int NREG = 8,
   parameter bit FWD  = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [11:0] i_instr,
   input  logic        i_stall,
   output logic [7:0]  o_s1,
   output logic [7:0]  o_s2,
   output logic [2:0]  o_func,
   output logic        o_en,
   input  logic [7:0]  i_result,
   input  logic        i_overflow,
   output logic        o_wb_valid,
   output logic [2:0]  o_wb_addr,
   output logic [7:0]  o_wb_data,
   output logic        o_flag_v,
   input  logic        i_dbg_we,
   input  logic [2:0]  i_dbg_addr,
   input  logic [7:0]  i_dbg_wdata,
   output logic [7:0]  o_dbg_rdata
);

   // Instruction fields
   logic [2:0] in_func, in_rd, in_rs1, in_rs2;
   assign in_func = i_instr[11:9];
   assign in_rd   = i_instr[8:6];
   assign in_rs1  = i_instr[5:3];
   assign in_rs2  = i_instr[2:0];

   // Architectural state
   logic [7:0] regs_q [0:NREG-1];
   logic [7:0] regs_d [0:NREG-1];
   logic       exec_valid_q, exec_valid_d;
   logic [2:0] exec_func_q, exec_func_d;
   logic [2:0] exec_rd_q, exec_rd_d;
   logic [7:0] exec_s1_q, exec_s1_d;
   logic [7:0] exec_s2_q, exec_s2_d;
   logic       flag_v_q, flag_v_d;

   // Handshake and hazard signals
   logic       wb_fire;
   logic       rs1_hit, rs2_hit;
   logic       hazard_bubble;
   logic       accept;
   logic [7:0] rs1_val, rs2_val;

   // Writeback, hazard detection and the accept handshake
   always_comb begin
      wb_fire       = exec_valid_q & ~i_stall;
      // A hit means the EXEC result lands this edge on a register being read now;
      // r0 never hits because it is constant.
      rs1_hit       = wb_fire && (in_rs1 != 3'd0) && (in_rs1 == exec_rd_q);
      rs2_hit       = wb_fire && (in_rs2 != 3'd0) && (in_rs2 == exec_rd_q);
      hazard_bubble = !FWD && i_valid && (rs1_hit || rs2_hit);
      o_ready       = ~i_stall & ~hazard_bubble;
      accept        = i_valid & o_ready;
   end

   // Operand read: r0 is zero, a hit forwards the live ALU result, else regfile
   always_comb begin
      rs1_val = (in_rs1 == 3'd0) ? 8'h00 : regs_q[in_rs1];
      rs2_val = (in_rs2 == 3'd0) ? 8'h00 : regs_q[in_rs2];
      if (FWD && rs1_hit) rs1_val = i_result;
      if (FWD && rs2_hit) rs2_val = i_result;
   end

   // EXEC slot next state: load on accept, drain on writeback, otherwise hold
   always_comb begin
      exec_valid_d = exec_valid_q;
      exec_func_d  = exec_func_q;
      exec_rd_d    = exec_rd_q;
      exec_s1_d    = exec_s1_q;
      exec_s2_d    = exec_s2_q;
      if (accept) begin
         exec_valid_d = 1'b1;
         exec_func_d  = in_func;
         exec_rd_d    = in_rd;
         exec_s1_d    = rs1_val;
         exec_s2_d    = rs2_val;
      end else if (wb_fire) begin
         exec_valid_d = 1'b0;
      end
   end

   // Register file and flag next state; writeback is applied after the debug write so it wins
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      flag_v_d = flag_v_q;
      if (i_dbg_we && (i_dbg_addr != 3'd0)) begin
         regs_d[i_dbg_addr] = i_dbg_wdata;
      end
      if (wb_fire) begin
         flag_v_d = i_overflow;
         if (exec_rd_q != 3'd0) begin
            regs_d[exec_rd_q] = i_result;
         end
      end
      regs_d[0] = 8'h00;
   end

   // State registers with asynchronous clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
         exec_valid_q <= 1'b0;
         exec_func_q  <= 3'd0;
         exec_rd_q    <= 3'd0;
         exec_s1_q    <= 8'h00;
         exec_s2_q    <= 8'h00;
         flag_v_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         exec_valid_q <= exec_valid_d;
         exec_func_q  <= exec_func_d;
         exec_rd_q    <= exec_rd_d;
         exec_s1_q    <= exec_s1_d;
         exec_s2_q    <= exec_s2_d;
         flag_v_q     <= flag_v_d;
      end
   end

   // Outputs come from EXEC registers only; the debug read is combinational
   always_comb begin
      o_s1        = exec_s1_q;
      o_s2        = exec_s2_q;
      o_func      = exec_func_q;
      o_en        = exec_valid_q;
      o_wb_valid  = wb_fire;
      o_wb_addr   = exec_rd_q;
      o_wb_data   = i_result;
      o_flag_v    = flag_v_q;
      o_dbg_rdata = regs_q[i_dbg_addr];
   end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: one instance with forwarding, one without, sharing stimulus.
// The bench models the external ALU and checks directed and random traffic.
module tb_alu_issue;

   logic        clk, rst, valid, stall, dbg_we;
   logic [11:0] instr;
   logic [2:0]  dbg_addr;
   logic [7:0]  dbg_wdata;

   logic        ready_a, en_a, ov_a, wbv_a, flag_a;
   logic [7:0]  s1_a, s2_a, res_a, wbd_a, rd_a;
   logic [2:0]  func_a, wba_a;
   logic        ready_b, en_b, ov_b, wbv_b, flag_b;
   logic [7:0]  s1_b, s2_b, res_b, wbd_b, rd_b;
   logic [2:0]  func_b, wba_b;

   int n_cmp = 0;
   int n_fail = 0;

   // External ALU: 0 add (carry), 1 sub (borrow), 2 and, 3 or, 4 xor, others pass s1
   function automatic logic [8:0] alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {(a < b), 8'(a - b)};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   function automatic logic [11:0] mk(input logic [2:0] f, input logic [2:0] d, input logic [2:0] r1, input logic [2:0] r2);
      return {f, d, r1, r2};
   endfunction

   assign {ov_a, res_a} = alu(func_a, s1_a, s2_a);
   assign {ov_b, res_b} = alu(func_b, s1_b, s2_b);

   alu_issue #(.NREG(8), .FWD(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_a), .i_instr(instr),
      .i_stall(stall), .o_s1(s1_a), .o_s2(s2_a), .o_func(func_a), .o_en(en_a),
      .i_result(res_a), .i_overflow(ov_a), .o_wb_valid(wbv_a), .o_wb_addr(wba_a),
      .o_wb_data(wbd_a), .o_flag_v(flag_a), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(rd_a));

   alu_issue #(.NREG(8), .FWD(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_b), .i_instr(instr),
      .i_stall(stall), .o_s1(s1_b), .o_s2(s2_b), .o_func(func_b), .o_en(en_b),
      .i_result(res_b), .i_overflow(ov_b), .o_wb_valid(wbv_b), .o_wb_addr(wba_b),
      .o_wb_data(wbd_b), .o_flag_v(flag_b), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(rd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; valid = 1'b0; stall = 1'b0; dbg_we = 1'b0; instr = 12'h000;
      dbg_addr = 3'd0; dbg_wdata = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic dbg_load(input logic [2:0] a, input logic [7:0] d);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      tick();
      dbg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL reset_en got %0h exp 0", en_a); end
      n_cmp++; if ({s1_a, s2_a} !== 16'h0000) begin n_fail++; $display("FAIL reset_ops got %h exp 0000", {s1_a, s2_a}); end
      n_cmp++; if (func_a !== 3'd0) begin n_fail++; $display("FAIL reset_func got %0h exp 0", func_a); end
      n_cmp++; if ({wbv_a, flag_a, wbv_b, flag_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_wb_flag got %b exp 0000", {wbv_a, flag_a, wbv_b, flag_b}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({ready_a, ready_b} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b exp 11", {ready_a, ready_b}); end
   endtask

   task automatic test_add();
      apply_reset();
      dbg_load(3'd1, 8'h05);
      dbg_load(3'd2, 8'h03);
      valid = 1'b1; instr = mk(3'd0, 3'd3, 3'd1, 3'd2);
      #1;
      n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL add_ready got %0h exp 1", ready_a); end
      n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL add_en_before got %0h exp 0", en_a); end
      tick();
      valid = 1'b0;
      #1;
      n_cmp++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL add_en got %0h exp 1", en_a); end
      n_cmp++; if ({s1_a, s2_a} !== 16'h0503) begin n_fail++; $display("FAIL add_ops got %h exp 0503", {s1_a, s2_a}); end
      n_cmp++; if ({wbv_a, wba_a, wbd_a} !== {1'b1, 3'd3, 8'h08}) begin n_fail++; $display("FAIL add_wb got %b/%0d/%h exp 1/3/08", wbv_a, wba_a, wbd_a); end
      tick();
      dbg_addr = 3'd3;
      #1;
      n_cmp++; if (flag_a !== 1'b0) begin n_fail++; $display("FAIL add_flag got %0h exp 0", flag_a); end
      n_cmp++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL add_en_clear got %0h exp 0", en_a); end
      n_cmp++; if (rd_a !== 8'h08) begin n_fail++; $display("FAIL add_r3 got %h exp 08", rd_a); end
   endtask

   task automatic test_overflow();
      apply_reset();
      dbg_load(3'd1, 8'hF0);
      dbg_load(3'd2, 8'h20);
      valid = 1'b1; instr = mk(3'd0, 3'd4, 3'd1, 3'd2);
      tick();
      valid = 1'b0;
      #1;
      n_cmp++; if (wbd_a !== 8'h10) begin n_fail++; $display("FAIL ovf_wbdata got %h exp 10", wbd_a); end
      tick();
      dbg_addr = 3'd4;
      #1;
      n_cmp++; if (flag_a !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0h exp 1", flag_a); end
      n_cmp++; if (rd_a !== 8'h10) begin n_fail++; $display("FAIL ovf_r4 got %h exp 10", rd_a); end
   endtask

   task automatic test_back_to_back_fwd();
      apply_reset();
      dbg_load(3'd1, 8'h01);
      dbg_load(3'd2, 8'h02);
      valid = 1'b1; instr = mk(3'd0, 3'd3, 3'd1, 3'd2);
      tick();
      instr = mk(3'd0, 3'd5, 3'd3, 3'd3);
      #1;
      n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_fwd_ready got %0h exp 1", ready_a); end
      n_cmp++; if (wbd_a !== 8'h03) begin n_fail++; $display("FAIL b2b_fwd_wb1 got %h exp 03", wbd_a); end
      tick();
      valid = 1'b0;
      #1;
      n_cmp++; if ({en_a, s1_a, s2_a} !== {1'b1, 8'h03, 8'h03}) begin n_fail++; $display("FAIL b2b_fwd_ops got %b/%h/%h exp 1/03/03", en_a, s1_a, s2_a); end
      n_cmp++; if ({wba_a, wbd_a} !== {3'd5, 8'h06}) begin n_fail++; $display("FAIL b2b_fwd_wb2 got %0d/%h exp 5/06", wba_a, wbd_a); end
      tick();
      dbg_addr = 3'd5;
      #1;
      n_cmp++; if (rd_a !== 8'h06) begin n_fail++; $display("FAIL b2b_fwd_r5 got %h exp 06", rd_a); end
   endtask

   task automatic test_back_to_back_nofwd();
      int  low;
      bit  acc;
      low = 0; acc = 1'b0;
      apply_reset();
      dbg_load(3'd1, 8'h01);
      dbg_load(3'd2, 8'h02);
      valid = 1'b1; instr = mk(3'd0, 3'd3, 3'd1, 3'd2);
      tick();
      instr = mk(3'd0, 3'd5, 3'd3, 3'd3);
      for (int k = 0; k < 5 && !acc; k++) begin
         #1;
         if (ready_b === 1'b1) acc = 1'b1;
         else low++;
         tick();
      end
      valid = 1'b0;
      #1;
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_nofwd_accept got %0d exp 1", acc); end
      n_cmp++; if (low !== 1) begin n_fail++; $display("FAIL b2b_nofwd_bubble got %0d exp 1", low); end
      n_cmp++; if ({en_b, s1_b, s2_b} !== {1'b1, 8'h03, 8'h03}) begin n_fail++; $display("FAIL b2b_nofwd_ops got %b/%h/%h exp 1/03/03", en_b, s1_b, s2_b); end
      n_cmp++; if ({wbv_b, wba_b, wbd_b} !== {1'b1, 3'd5, 8'h06}) begin n_fail++; $display("FAIL b2b_nofwd_wb got %b/%0d/%h exp 1/5/06", wbv_b, wba_b, wbd_b); end
      tick();
      dbg_addr = 3'd5;
      #1;
      n_cmp++; if (rd_b !== 8'h06) begin n_fail++; $display("FAIL b2b_nofwd_r5 got %h exp 06", rd_b); end
   endtask

   task automatic test_stall();
      apply_reset();
      dbg_load(3'd1, 8'h05);
      dbg_load(3'd2, 8'h03);
      valid = 1'b1; instr = mk(3'd0, 3'd3, 3'd1, 3'd2);
      tick();
      instr = mk(3'd0, 3'd6, 3'd1, 3'd1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if ({en_a, s1_a, s2_a} !== {1'b1, 8'h05, 8'h03}) begin n_fail++; $display("FAIL stall_hold%0d got %b/%h/%h exp 1/05/03", k, en_a, s1_a, s2_a); end
         n_cmp++; if ({wbv_a, ready_a} !== 2'b00) begin n_fail++; $display("FAIL stall_wb_ready%0d got %b exp 00", k, {wbv_a, ready_a}); end
         tick();
      end
      stall = 1'b0;
      #1;
      n_cmp++; if ({wbv_a, wbd_a, ready_a} !== {1'b1, 8'h08, 1'b1}) begin n_fail++; $display("FAIL stall_release got %b/%h/%b exp 1/08/1", wbv_a, wbd_a, ready_a); end
      tick();
      valid = 1'b0;
      #1;
      n_cmp++; if ({s1_a, s2_a, wba_a, wbd_a} !== {8'h05, 8'h05, 3'd6, 8'h0A}) begin n_fail++; $display("FAIL stall_next got %h/%h/%0d/%h exp 05/05/6/0a", s1_a, s2_a, wba_a, wbd_a); end
   endtask

   task automatic test_dbg_collision();
      apply_reset();
      dbg_load(3'd1, 8'h07);
      valid = 1'b1; instr = mk(3'd0, 3'd2, 3'd1, 3'd1);
      dbg_we = 1'b1; dbg_addr = 3'd1; dbg_wdata = 8'h99;
      tick();
      valid = 1'b0;
      dbg_addr = 3'd2; dbg_wdata = 8'h55;
      #1;
      n_cmp++; if ({s1_a, s2_a} !== 16'h0707) begin n_fail++; $display("FAIL dbg_prewrite got %h exp 0707", {s1_a, s2_a}); end
      n_cmp++; if ({wbv_a, wba_a, wbd_a} !== {1'b1, 3'd2, 8'h0E}) begin n_fail++; $display("FAIL dbg_wb got %b/%0d/%h exp 1/2/0e", wbv_a, wba_a, wbd_a); end
      tick();
      dbg_we = 1'b0;
      #1;
      n_cmp++; if (rd_a !== 8'h0E) begin n_fail++; $display("FAIL dbg_wb_wins got %h exp 0e", rd_a); end
      dbg_addr = 3'd1;
      #1;
      n_cmp++; if (rd_a !== 8'h99) begin n_fail++; $display("FAIL dbg_r1 got %h exp 99", rd_a); end
   endtask

   task automatic test_r0();
      apply_reset();
      dbg_load(3'd1, 8'hF0);
      dbg_load(3'd2, 8'h20);
      valid = 1'b1; instr = mk(3'd0, 3'd0, 3'd1, 3'd2);
      tick();
      valid = 1'b0;
      dbg_we = 1'b1; dbg_addr = 3'd0; dbg_wdata = 8'hAA;
      #1;
      n_cmp++; if ({wbv_a, wba_a, wbd_a} !== {1'b1, 3'd0, 8'h10}) begin n_fail++; $display("FAIL r0_wb got %b/%0d/%h exp 1/0/10", wbv_a, wba_a, wbd_a); end
      tick();
      dbg_we = 1'b0;
      #1;
      n_cmp++; if (rd_a !== 8'h00) begin n_fail++; $display("FAIL r0_read got %h exp 00", rd_a); end
      n_cmp++; if (flag_a !== 1'b1) begin n_fail++; $display("FAIL r0_flag got %0h exp 1", flag_a); end
   endtask

   task automatic test_reset_inflight();
      dbg_load(3'd1, 8'h01);
      dbg_load(3'd2, 8'h02);
      valid = 1'b1; instr = mk(3'd3, 3'd3, 3'd1, 3'd2);
      tick();
      valid = 1'b0;
      #1;
      n_cmp++; if ({en_a, func_a} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL rstf_pre got %b/%0d exp 1/3", en_a, func_a); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({wbv_a, en_a, flag_a} !== 3'b000) begin n_fail++; $display("FAIL rstf_ctrl got %b exp 000", {wbv_a, en_a, flag_a}); end
      n_cmp++; if ({s1_a, s2_a, func_a} !== 19'h0) begin n_fail++; $display("FAIL rstf_ops got %h/%h/%0d exp 0/0/0", s1_a, s2_a, func_a); end
      for (int a = 0; a < 8; a++) begin
         dbg_addr = 3'(a);
         #1;
         n_cmp++; if (rd_a !== 8'h00) begin n_fail++; $display("FAIL rstf_reg%0d got %h exp 00", a, rd_a); end
      end
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if ({ready_a, en_a, wbv_a} !== 3'b100) begin n_fail++; $display("FAIL rstf_after got %b exp 100", {ready_a, en_a, wbv_a}); end
   endtask

   // Architectural model: instructions apply in acceptance order to a register
   // array; writebacks are expected in that same order, one in flight at most.
   task automatic test_random(input bit fwd);
      logic [7:0] mr [8];
      logic [2:0] qa [$];
      logic [7:0] qd [$];
      logic       qo [$];
      bit         infl, exp_flag, wbm, haz, rdy;
      logic [2:0] infl_rd, f, d, r1, r2, ga;
      logic [8:0] r;
      logic       g_ready, g_en, g_wbv, g_flag;
      logic [7:0] g_wbd;
      apply_reset();
      mr[0] = 8'h00;
      for (int a = 1; a < 8; a++) begin
         mr[a] = 8'($urandom);
         dbg_load(3'(a), mr[a]);
      end
      infl = 1'b0; infl_rd = 3'd0; exp_flag = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         valid = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) < 2);
         instr = 12'($urandom);
         if (cyc >= 397) begin valid = 1'b0; stall = 1'b0; end
         #1;
         {f, d, r1, r2} = instr;
         g_ready = fwd ? ready_a : ready_b;
         g_en    = fwd ? en_a    : en_b;
         g_wbv   = fwd ? wbv_a   : wbv_b;
         g_flag  = fwd ? flag_a  : flag_b;
         ga      = fwd ? wba_a   : wba_b;
         g_wbd   = fwd ? wbd_a   : wbd_b;
         wbm = infl && !stall;
         haz = !fwd && valid && wbm && (((r1 != 3'd0) && (r1 == infl_rd)) || ((r2 != 3'd0) && (r2 == infl_rd)));
         rdy = !stall && !haz;
         n_cmp++; if (g_ready !== rdy) begin n_fail++; $display("FAIL rnd%0d_ready c%0d got %b exp %b", fwd, cyc, g_ready, rdy); end
         n_cmp++; if (g_en !== infl) begin n_fail++; $display("FAIL rnd%0d_en c%0d got %b exp %b", fwd, cyc, g_en, infl); end
         n_cmp++; if (g_wbv !== wbm) begin n_fail++; $display("FAIL rnd%0d_wbv c%0d got %b exp %b", fwd, cyc, g_wbv, wbm); end
         n_cmp++; if (g_flag !== exp_flag) begin n_fail++; $display("FAIL rnd%0d_flag c%0d got %b exp %b", fwd, cyc, g_flag, exp_flag); end
         if (wbm && qa.size() > 0) begin
            n_cmp++; if ({ga, g_wbd} !== {qa[0], qd[0]}) begin n_fail++; $display("FAIL rnd%0d_wb c%0d got %0d/%h exp %0d/%h", fwd, cyc, ga, g_wbd, qa[0], qd[0]); end
            exp_flag = qo[0];
            void'(qa.pop_front()); void'(qd.pop_front()); void'(qo.pop_front());
         end
         if (valid && rdy) begin
            r = alu(f, mr[r1], mr[r2]);
            if (d != 3'd0) mr[d] = r[7:0];
            qa.push_back(d); qd.push_back(r[7:0]); qo.push_back(r[8]);
            infl = 1'b1; infl_rd = d;
         end else if (wbm) begin
            infl = 1'b0;
         end
         tick();
      end
      #1;
      g_flag = fwd ? flag_a : flag_b;
      n_cmp++; if (g_flag !== exp_flag) begin n_fail++; $display("FAIL rnd%0d_flag_end got %b exp %b", fwd, g_flag, exp_flag); end
      for (int a = 0; a < 8; a++) begin
         dbg_addr = 3'(a);
         #1;
         g_wbd = fwd ? rd_a : rd_b;
         n_cmp++; if (g_wbd !== mr[a]) begin n_fail++; $display("FAIL rnd%0d_reg%0d got %h exp %h", fwd, a, g_wbd, mr[a]); end
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_add();
      test_overflow();
      test_back_to_back_fwd();
      test_back_to_back_nofwd();
      test_stall();
      test_dbg_collision();
      test_r0();
      test_reset_inflight();
      test_random(1'b1);
      test_random(1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter NREG, default 8, number of 8-bit general registers; fixed at 8 because the register address fields are 3 bits.
REQ-002 Parameter FWD, default 1'b1, enables result forwarding; 1'b0 inserts a one-cycle bubble on a read-after-write hazard instead.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  instruction present on i_instr.
REQ-006 o_ready  output  1  stage can accept; transfer occurs when i_valid & o_ready at a rising edge.
REQ-007 i_instr  input  12  [11:9] func, [8:6] rd, [5:3] rs1, [2:0] rs2.
REQ-008 i_stall  input  1  downstream hold; freezes the EXEC stage.
REQ-009 o_s1, o_s2  output  8 each  operands to the ALU.
REQ-010 o_func  output  3  ALU function; o_en  output  1  ALU enable, equal to exec_valid.
REQ-011 i_result  input  8  ALU result; i_overflow  input  1  ALU carry/overflow.
REQ-012 o_wb_valid  output  1  writeback occurs this cycle; o_wb_addr  output  3  writeback register; o_wb_data  output  8  writeback data.
REQ-013 o_flag_v  output  1  registered overflow flag of the last writeback.
REQ-014 i_dbg_we  input  1, i_dbg_addr  input  3, i_dbg_wdata  input  8  register load port; o_dbg_rdata  output  8  combinational read of regs[i_dbg_addr].

Function
REQ-015 Pipeline has two stages: ACCEPT (register read) and EXEC (ALU operands driven, result written back); there is one EXEC slot with flag exec_valid.
REQ-016 On an accepted instruction, the EXEC registers load func, rd, the rs1 operand and the rs2 operand, and exec_valid is set at the same edge; o_en is high in the following cycle.
REQ-017 o_s1, o_s2, o_func and o_en are driven only from EXEC registers, never combinationally from i_instr.
REQ-018 Writeback fires when exec_valid & ~i_stall: o_wb_valid=1, o_wb_addr=rd, o_wb_data=i_result; regs[rd] and o_flag_v update at that edge.
REQ-019 Register 0 reads as 8'h00 always; writes to r0 are discarded, but o_flag_v still updates.
REQ-020 o_ready = ~i_stall & ~hazard_bubble; throughput is 1 instruction per cycle without stall or bubble.
REQ-021 When i_stall=1, the EXEC contents and o_en hold, no writeback occurs, and no instruction is accepted.
REQ-022 When exec_valid=1, i_stall=0 and the exec rd equals an incoming nonzero rs, the following applies.
  - FWD=1: the operand takes i_result.
  - FWD=0: o_ready is low for that cycle, and the instruction is accepted on the next cycle from the register file.
REQ-023 When no instruction is accepted and writeback fires, exec_valid clears at the next edge; an accept in the same cycle keeps exec_valid set (back-to-back).
REQ-024 Debug write applies on a rising edge when i_dbg_we=1 and addr!=0; if it coincides with a writeback to the same register, the writeback wins.
REQ-025 A debug write and an accept in the same cycle: the accept reads the pre-write value unless forwarding applies.
REQ-026 All register-file arithmetic is 8-bit; there is no width extension, and overflow is reported only via i_overflow.

Reset
REQ-027 While i_rst=1, asynchronously:
  - all regs=0, exec_valid=0;
  - o_en=0, o_s1=o_s2=0, o_func=0;
  - o_wb_valid=0, o_flag_v=0.
REQ-028 Assertion of reset with an instruction in EXEC discards it without writeback; o_ready is 1 in the first cycle after deassertion if i_stall=0.

Verification
REQ-029 Debug load r1=8'h05, r2=8'h03; issue add r3,r1,r2 -> o_en=1 next cycle with o_s1=05, o_s2=03; o_wb_valid with r3=08 and o_flag_v=0.
REQ-030 r1=8'hF0, r2=8'h20; add r4,r1,r2 -> r4=8'h10, o_flag_v=1.
REQ-031 Back-to-back add r3,r1,r2 then add r5,r3,r3 with r1=1, r2=2 (FWD=1) -> the second instruction sees o_s1=o_s2=03, r5=06, with no bubble.
REQ-032 Same sequence with FWD=0 -> o_ready=0 for exactly one cycle and r5=06.
REQ-033 i_stall=1 for 3 cycles with an instruction in EXEC -> o_en and operands held, o_wb_valid=0, o_ready=0; writeback occurs on the first cycle after i_stall drops.
REQ-034 add r0,r1,r2 -> o_dbg_rdata(0)=00; then i_rst pulsed with an instruction in EXEC -> no writeback, and all regs read 00.
